// File: rtl/riscv_defines.sv
// Shared core definitions: memory access types, stall FSM states and hazard helpers.
package riscv_defines;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } memaccess_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } stall_state_t;

  // Width of the bubble bookkeeping; LOAD_BUBBLES must fit (1..15).
  localparam int BUBBLE_W = 4;

  // A D-stage source collides with the E-stage destination (x0 never collides).
  function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
    return used && (rs != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_load_use_detector.sv
// Combinational load-use detection between the E-stage load and the D-stage consumer.
// Reports whether a stall is needed and how many bubbles the forwarding network cannot cover.
module hazard_load_use_detector
  import riscv_defines::*;
#(
  parameter int LOAD_BUBBLES = 2
) (
  input  memaccess_t            memaccess_e,
  input  logic                  regwrite_e,
  input  logic [4:0]            rd_e,
  input  logic [4:0]            rs1_d,
  input  logic [4:0]            rs2_d,
  input  logic                  use_rs1_d,
  input  logic                  use_rs2_d,
  input  memaccess_t            memaccess_d,
  output logic                  lu_hit,
  output logic [BUBBLE_W-1:0]   need
);

  logic hit1;
  logic hit2;
  logic full_distance;

  // Store data (rs2 of a store) can be picked up late by the W->M1 forwarder, so it needs one bubble less.
  always_comb begin
    hit1          = src_hit(use_rs1_d, rs1_d, rd_e);
    hit2          = src_hit(use_rs2_d, rs2_d, rd_e);
    lu_hit        = (memaccess_e == MEM_READ) && regwrite_e && (hit1 || hit2);
    full_distance = hit1 || (hit2 && (memaccess_d != MEM_WRITE));
    if (full_distance) begin
      need = BUBBLE_W'(LOAD_BUBBLES);
    end else begin
      need = BUBBLE_W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Central stall/bubble sequencer for the F/D/E/M1/M2/W pipeline.
// Inserts load-use bubbles, freezes the pipe during pending M1 memory handshakes,
// flushes D on E-stage redirects and counts stalled cycles.
module hazard_stall_controller
  import riscv_defines::*;
#(
  parameter int LOAD_BUBBLES = 2,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  memaccess_t        memaccess_e,
  input  logic              regwrite_e,
  input  logic [4:0]        rd_e,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  input  memaccess_t        memaccess_d,
  input  logic              dmem_req_m1,
  input  logic              dmem_ready,
  input  logic              redirect_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m1,
  output logic              bubble_e,
  output logic              bubble_m2,
  output logic              flush_d,
  output logic [PERF_W-1:0] stall_cycles
);

  stall_state_t          state;
  stall_state_t          state_next;
  stall_state_t          saved;
  stall_state_t          saved_next;
  logic [BUBBLE_W-1:0]   remaining;
  logic [BUBBLE_W-1:0]   remaining_next;
  logic                  lu_hit;
  logic [BUBBLE_W-1:0]   need;
  logic                  mem_wait;

  assign mem_wait = dmem_req_m1 && !dmem_ready;

  hazard_load_use_detector #(
    .LOAD_BUBBLES (LOAD_BUBBLES)
  ) u_detector (
    .memaccess_e (memaccess_e),
    .regwrite_e  (regwrite_e),
    .rd_e        (rd_e),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .use_rs1_d   (use_rs1_d),
    .use_rs2_d   (use_rs2_d),
    .memaccess_d (memaccess_d),
    .lu_hit      (lu_hit),
    .need        (need)
  );

  // State register: current state, state to resume after a memory wait, bubbles still owed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      saved     <= ST_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      saved     <= saved_next;
      remaining <= remaining_next;
    end
  end

  // Next-state logic: a pending memory handshake always wins; a memory wait leaves the bubble count untouched.
  always_comb begin
    state_next     = state;
    saved_next     = saved;
    remaining_next = remaining;
    case (state)
      ST_IDLE: begin
        if (mem_wait) begin
          state_next = ST_MEM_WAIT;
          saved_next = ST_IDLE;
        end else if (redirect_e) begin
          state_next = ST_IDLE;
        end else if (lu_hit) begin
          remaining_next = need - BUBBLE_W'(1);
          if (need > BUBBLE_W'(1)) begin
            state_next = ST_LU_STALL;
          end
        end
      end
      ST_LU_STALL: begin
        if (mem_wait) begin
          state_next = ST_MEM_WAIT;
          saved_next = ST_LU_STALL;
        end else if (redirect_e) begin
          state_next     = ST_IDLE;
          remaining_next = '0;
        end else if (remaining <= BUBBLE_W'(1)) begin
          state_next     = ST_IDLE;
          remaining_next = '0;
        end else begin
          remaining_next = remaining - BUBBLE_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = saved;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        saved_next     = ST_IDLE;
        remaining_next = '0;
      end
    endcase
  end

  // Output decode: combinational from state and inputs, forced quiet while reset is held.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m1  = 1'b0;
    bubble_e  = 1'b0;
    bubble_m2 = 1'b0;
    flush_d   = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (mem_wait) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            stall_m1  = 1'b1;
            bubble_m2 = 1'b1;
          end else if (redirect_e) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
          end else if (lu_hit) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
          end
        end
        ST_LU_STALL: begin
          if (mem_wait) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            stall_m1  = 1'b1;
            bubble_m2 = 1'b1;
          end else if (redirect_e) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
          end else begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            stall_m1  = 1'b1;
            bubble_m2 = 1'b1;
          end
        end
        default: begin
          stall_f = 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the front end was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall_d && (stall_cycles != {PERF_W{1'b1}})) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed vector table, hand-written
// reset/saturation sequences and randomized stimulus against a bubble-counting model.
module tb_hazard_stall_controller;
  import riscv_defines::*;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_FRZ  = 7'b1111010;
  localparam logic [6:0] C_RED  = 7'b0000101;

  logic        clk = 1'b0;
  logic        reset;
  memaccess_t  memaccess_e;
  logic        regwrite_e;
  logic [4:0]  rd_e;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic        use_rs1_d;
  logic        use_rs2_d;
  memaccess_t  memaccess_d;
  logic        dmem_req_m1;
  logic        dmem_ready;
  logic        redirect_e;

  logic        stall_f, stall_d, stall_e, stall_m1, bubble_e, bubble_m2, flush_d;
  logic [15:0] stall_cycles;
  logic        sat_stall_f, sat_stall_d, sat_stall_e, sat_stall_m1;
  logic        sat_bubble_e, sat_bubble_m2, sat_flush_d;
  logic [3:0]  sat_stall_cycles;
  logic [6:0]  ctrl;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    memaccess_t me;
    logic       rw;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    memaccess_t md;
    logic       req;
    logic       rdy;
    logic       redir;
    logic [6:0] exp_ctrl;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[23];

  assign ctrl = {stall_f, stall_d, stall_e, stall_m1, bubble_e, bubble_m2, flush_d};

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk          (clk),
    .reset        (reset),
    .memaccess_e  (memaccess_e),
    .regwrite_e   (regwrite_e),
    .rd_e         (rd_e),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .use_rs1_d    (use_rs1_d),
    .use_rs2_d    (use_rs2_d),
    .memaccess_d  (memaccess_d),
    .dmem_req_m1  (dmem_req_m1),
    .dmem_ready   (dmem_ready),
    .redirect_e   (redirect_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m1     (stall_m1),
    .bubble_e     (bubble_e),
    .bubble_m2    (bubble_m2),
    .flush_d      (flush_d),
    .stall_cycles (stall_cycles)
  );

  hazard_stall_controller #(.LOAD_BUBBLES(2), .PERF_W(4)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .memaccess_e  (memaccess_e),
    .regwrite_e   (regwrite_e),
    .rd_e         (rd_e),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .use_rs1_d    (use_rs1_d),
    .use_rs2_d    (use_rs2_d),
    .memaccess_d  (memaccess_d),
    .dmem_req_m1  (dmem_req_m1),
    .dmem_ready   (dmem_ready),
    .redirect_e   (redirect_e),
    .stall_f      (sat_stall_f),
    .stall_d      (sat_stall_d),
    .stall_e      (sat_stall_e),
    .stall_m1     (sat_stall_m1),
    .bubble_e     (sat_bubble_e),
    .bubble_m2    (sat_bubble_m2),
    .flush_d      (sat_flush_d),
    .stall_cycles (sat_stall_cycles)
  );

  function automatic vec_t mk(input memaccess_t me, input logic rw, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input memaccess_t md, input logic req,
                              input logic rdy, input logic redir, input logic [6:0] exp_ctrl,
                              input int exp_cnt);
    vec_t v;
    v.me = me; v.rw = rw; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.md = md; v.req = req; v.rdy = rdy; v.redir = redir;
    v.exp_ctrl = exp_ctrl; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic apply_stimulus(input memaccess_t me, input logic rw, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input memaccess_t md, input logic req,
                                input logic rdy, input logic redir);
    memaccess_e = me;  regwrite_e = rw;  rd_e = rd;
    rs1_d = rs1;       rs2_d = rs2;      use_rs1_d = u1;  use_rs2_d = u2;
    memaccess_d = md;  dmem_req_m1 = req; dmem_ready = rdy; redirect_e = redir;
  endtask

  task automatic apply_idle();
    apply_stimulus(MEM_NONE, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MEM_NONE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Randomized run against a model that tracks owed bubbles and whether M1 is waiting.
  task automatic run_random(input int n);
    int         owed = 0;
    bit         frozen = 1'b0;
    int         cnt16 = 0;
    int         cnt4 = 0;
    logic [6:0] exp;
    logic [1:0] r;
    memaccess_t me, md;
    logic       h1, h2, lu, mw;
    int         need;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) < 2);
      r  = 2'($urandom_range(0, 2));
      me = (r == 2'd1) ? MEM_READ : (r == 2'd2) ? MEM_WRITE : MEM_NONE;
      r  = 2'($urandom_range(0, 2));
      md = (r == 2'd1) ? MEM_READ : (r == 2'd2) ? MEM_WRITE : MEM_NONE;
      apply_stimulus(me, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), md,
                     ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 50),
                     ($urandom_range(0, 99) < 10));
      if (reset) begin
        owed = 0; frozen = 1'b0; cnt16 = 0; cnt4 = 0;
      end
      h1   = use_rs1_d && (rs1_d != 5'd0) && (rs1_d == rd_e);
      h2   = use_rs2_d && (rs2_d != 5'd0) && (rs2_d == rd_e);
      lu   = (memaccess_e == MEM_READ) && regwrite_e && (h1 || h2);
      need = (h1 || (h2 && memaccess_d != MEM_WRITE)) ? 2 : 1;
      mw   = dmem_req_m1 && !dmem_ready;
      exp  = C_NONE;
      if (!reset) begin
        if (frozen) begin
          if (!dmem_ready) exp = C_FRZ;
        end else if (mw) begin
          exp = C_FRZ;
        end else if (redirect_e) begin
          exp = C_RED;
        end else if (owed > 0) begin
          exp = C_LU;
        end else if (lu) begin
          exp = C_LU;
        end
      end
      #1;
      check_output("rand_ctrl", 32'(ctrl), 32'(exp));
      check_output("rand_cnt", 32'(stall_cycles), 32'(cnt16));
      check_output("rand_cnt_sat", 32'(sat_stall_cycles), 32'(cnt4));
      if (!reset) begin
        if (frozen) begin
          if (dmem_ready) frozen = 1'b0;
        end else if (mw) begin
          frozen = 1'b1;
        end else if (redirect_e) begin
          owed = 0;
        end else if (owed > 0) begin
          owed = owed - 1;
        end else if (lu) begin
          owed = need - 1;
        end
        if (exp[5]) begin
          if (cnt16 < 65535) cnt16++;
          if (cnt4 < 15) cnt4++;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk(MEM_READ,  1, 5, 5, 0, 1, 0, MEM_NONE,  0, 0, 0, C_LU,   0);
    vecs[1]  = mk(MEM_NONE,  0, 0, 5, 0, 1, 0, MEM_NONE,  0, 0, 0, C_LU,   1);
    vecs[2]  = mk(MEM_NONE,  1, 6, 0, 0, 0, 0, MEM_NONE,  0, 0, 0, C_NONE, 2);
    vecs[3]  = mk(MEM_READ,  1, 5, 1, 5, 1, 1, MEM_WRITE, 0, 0, 0, C_LU,   2);
    vecs[4]  = mk(MEM_NONE,  0, 0, 0, 0, 0, 0, MEM_NONE,  0, 0, 0, C_NONE, 3);
    vecs[5]  = mk(MEM_READ,  1, 5, 5, 7, 1, 1, MEM_WRITE, 0, 0, 0, C_LU,   3);
    vecs[6]  = mk(MEM_NONE,  0, 0, 5, 7, 1, 1, MEM_WRITE, 0, 0, 0, C_LU,   4);
    vecs[7]  = mk(MEM_NONE,  0, 0, 0, 0, 0, 0, MEM_NONE,  0, 0, 0, C_NONE, 5);
    vecs[8]  = mk(MEM_READ,  1, 5, 0, 5, 0, 1, MEM_NONE,  0, 0, 0, C_LU,   5);
    vecs[9]  = mk(MEM_NONE,  0, 0, 0, 5, 0, 1, MEM_NONE,  1, 0, 0, C_FRZ,  6);
    vecs[10] = mk(MEM_NONE,  0, 0, 0, 5, 0, 1, MEM_NONE,  1, 0, 0, C_FRZ,  7);
    vecs[11] = mk(MEM_NONE,  0, 0, 0, 5, 0, 1, MEM_NONE,  1, 0, 0, C_FRZ,  8);
    vecs[12] = mk(MEM_NONE,  0, 0, 0, 5, 0, 1, MEM_NONE,  1, 1, 0, C_NONE, 9);
    vecs[13] = mk(MEM_NONE,  0, 0, 0, 5, 0, 1, MEM_NONE,  0, 0, 0, C_LU,   9);
    vecs[14] = mk(MEM_NONE,  0, 0, 0, 0, 0, 0, MEM_NONE,  0, 0, 0, C_NONE, 10);
    vecs[15] = mk(MEM_READ,  1, 5, 5, 0, 1, 0, MEM_NONE,  0, 0, 1, C_RED,  10);
    vecs[16] = mk(MEM_NONE,  0, 0, 0, 0, 0, 0, MEM_NONE,  0, 0, 0, C_NONE, 10);
    vecs[17] = mk(MEM_READ,  1, 0, 0, 0, 1, 1, MEM_NONE,  0, 0, 0, C_NONE, 10);
    vecs[18] = mk(MEM_READ,  0, 5, 5, 0, 1, 0, MEM_NONE,  0, 0, 0, C_NONE, 10);
    vecs[19] = mk(MEM_READ,  1, 5, 5, 0, 1, 0, MEM_NONE,  1, 0, 1, C_FRZ,  10);
    vecs[20] = mk(MEM_NONE,  0, 0, 0, 0, 0, 0, MEM_NONE,  1, 1, 0, C_NONE, 11);
    vecs[21] = mk(MEM_NONE,  0, 0, 0, 0, 0, 0, MEM_NONE,  0, 0, 0, C_NONE, 11);
    vecs[22] = mk(MEM_WRITE, 1, 5, 5, 0, 1, 0, MEM_NONE,  0, 0, 0, C_NONE, 11);

    reset = 1'b1;
    apply_idle();
    @(negedge clk);
    apply_stimulus(MEM_READ, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, MEM_NONE, 1'b1, 1'b0, 1'b1);
    #1;
    check_output("reset_ctrl", 32'(ctrl), 32'(C_NONE));
    check_output("reset_cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply_idle();

    // Directed vector table, one row per cycle.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i].me, vecs[i].rw, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                     vecs[i].u1, vecs[i].u2, vecs[i].md, vecs[i].req, vecs[i].rdy, vecs[i].redir);
      #1;
      if (ctrl !== vecs[i].exp_ctrl) begin
        $display("[TB] row %0d", i);
      end
      check_output("table_ctrl", 32'(ctrl), 32'(vecs[i].exp_ctrl));
      check_output("table_cnt", 32'(stall_cycles), 32'(vecs[i].exp_cnt));
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    apply_stimulus(MEM_READ, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, MEM_NONE, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("midrst_first_bubble", 32'(ctrl), 32'(C_LU));
    @(negedge clk);
    apply_stimulus(MEM_NONE, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, MEM_NONE, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("midrst_second_bubble", 32'(ctrl), 32'(C_LU));
    #1;
    reset = 1'b1;
    #1;
    check_output("midrst_ctrl", 32'(ctrl), 32'(C_NONE));
    check_output("midrst_cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("midrst_idle_after", 32'(ctrl), 32'(C_NONE));
    check_output("midrst_cnt_after", 32'(stall_cycles), 32'd0);

    // Twenty consecutive frozen cycles saturate the 4-bit counter at 15.
    @(negedge clk);
    apply_stimulus(MEM_NONE, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MEM_NONE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    check_output("sat_still_frozen", 32'(ctrl), 32'(C_FRZ));
    check_output("sat_cnt_16", 32'(stall_cycles), 32'd20);
    check_output("sat_cnt_4", 32'(sat_stall_cycles), 32'd15);
    dmem_ready = 1'b1;
    #1;
    check_output("sat_exit_cycle", 32'(ctrl), 32'(C_NONE));
    @(negedge clk);
    reset = 1'b1;
    apply_idle();
    @(negedge clk);
    reset = 1'b0;

    run_random(600);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
